tune_scheduler: RTL and testbench

- Sequences a stored melody into the tone generator that drives the speaker.
- Steps through a note table in external synchronous memory, one entry per note.
- For each note, drives the half-period code (`speaker_data`) and the `play` enable for a programmed duration, then inserts a short articulation gap.
- A live key input preempts melody playback. It pauses the melody, and playback resumes exactly where it stopped when the key is released.

---
 rtl/tune_if.sv | 28 ++
 rtl/tune_scheduler.sv | 178 +++++++++++++++++
 tb/tb_tune_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tune_if.sv
// Melody scheduler bus: control pulses, live key input, note-table read port
// and the tone-generator outputs, grouped so they travel as one port.
interface tune_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              key_hold;
  logic [15:0]       key_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [24:0]       mem_data;
  logic [15:0]       speaker_data;
  logic              play;
  logic              busy;
  logic              done;

  // Controller / memory side.
  modport master (
    output start, stop, key_hold, key_data, mem_data,
    input  mem_addr, speaker_data, play, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, stop, key_hold, key_data, mem_data,
    output mem_addr, speaker_data, play, busy, done
  );
endinterface

// File: rtl/tune_scheduler.sv
// Melody sequencer: walks a note table in synchronous memory and drives the
// tone generator for each note's duration, with a silent gap after every note.
// A held live key preempts playback and freezes the sequencer in place.
module tune_scheduler #(
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 10,
  parameter int ADDR_W   = 8
) (
  input  logic   sys_clk,
  input  logic   sys_rst,
  tune_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_NOTE, S_GAP} state_t;

  state_t            r_state,   w_state;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [15:0]       r_speaker, w_speaker;
  logic              r_play,    w_play;
  logic              r_done,    w_done;
  logic [PRE_W-1:0]  r_pre,     w_pre;
  logic [7:0]        r_dur,     w_dur;
  logic [GAP_W-1:0]  r_gap,     w_gap;
  logic [15:0]       r_saved,   w_saved;
  logic              r_paused;
  logic              w_tick;
  logic              w_advance;

  wire        w_end_flag = bus.mem_data[24];
  wire [7:0]  w_duration = bus.mem_data[23:16];
  wire [15:0] w_half     = bus.mem_data[15:0];

  assign w_tick = (r_pre == PRE_MAX);

  // State register and all datapath registers; everything clears on reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
      r_speaker  <= '0;
      r_play     <= 1'b0;
      r_done     <= 1'b0;
      r_pre      <= '0;
      r_dur      <= '0;
      r_gap      <= '0;
      r_saved    <= '0;
      r_paused   <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the same pre-edge values; blocking here would create order-dependent races.
      r_state    <= w_state;
      r_mem_addr <= w_mem_addr;
      r_speaker  <= w_speaker;
      r_play     <= w_play;
      r_done     <= w_done;
      r_pre      <= w_pre;
      r_dur      <= w_dur;
      r_gap      <= w_gap;
      r_saved    <= w_saved;
      r_paused   <= bus.key_hold;
    end
  end

  // Next-state and next-output logic: stop first, then freeze under key,
  // otherwise normal sequencing; the live key overrides the speaker last.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned, which would infer a latch.
    w_state    = r_state;
    w_mem_addr = r_mem_addr;
    w_speaker  = r_speaker;
    w_play     = r_play;
    w_done     = 1'b0;
    w_pre      = r_pre;
    w_dur      = r_dur;
    w_gap      = r_gap;
    w_saved    = r_saved;
    w_advance  = 1'b0;

    if (bus.stop) begin
      // Abort wins over start and over the key freeze; counters are discarded.
      w_state   = S_IDLE;
      w_speaker = '0;
      w_play    = 1'b0;
      w_pre     = '0;
      w_dur     = '0;
      w_gap     = '0;
    end else if (!bus.key_hold) begin
      // First cycle after a key release: put back what the melody was playing.
      if (r_paused) begin
        if (r_state == S_NOTE) begin
          w_speaker = r_saved;
          w_play    = |r_saved;
        end else begin
          w_speaker = '0;
          w_play    = 1'b0;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_mem_addr = '0;
            w_state    = S_FETCH;
          end
        end
        S_FETCH: w_state = S_LOAD;
        S_LOAD: begin
          if (w_end_flag) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end else if (w_duration == 8'd0) begin
            w_advance = 1'b1;
          end else begin
            w_speaker = w_half;
            w_saved   = w_half;
            w_play    = |w_half;
            w_dur     = w_duration;
            w_pre     = '0;
            w_state   = S_NOTE;
          end
        end
        S_NOTE: begin
          w_pre = w_tick ? '0 : r_pre + PRE_W'(1);
          if (w_tick) begin
            w_dur = r_dur - 8'd1;
            if (r_dur == 8'd1) begin
              w_speaker = '0;
              w_play    = 1'b0;
              if (GAP_MS > 0) begin
                w_gap   = GAP_W'(GAP_MS);
                w_pre   = '0;
                w_state = S_GAP;
              end else begin
                w_advance = 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          w_pre = w_tick ? '0 : r_pre + PRE_W'(1);
          if (w_tick) begin
            w_gap = r_gap - GAP_W'(1);
            if (r_gap == GAP_W'(1)) w_advance = 1'b1;
          end
        end
        default: w_state = S_IDLE;
      endcase

      // Move to the next entry, or finish at the top of the table.
      if (w_advance) begin
        if (r_mem_addr == '1) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          w_mem_addr = r_mem_addr + ADDR_W'(1);
          w_state    = S_FETCH;
        end
      end
    end

    if (bus.key_hold) begin
      w_speaker = bus.key_data;
      w_play    = |bus.key_data;
    end
  end

  assign bus.mem_addr     = r_mem_addr;
  assign bus.speaker_data = r_speaker;
  assign bus.play         = r_play;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;

endmodule

// File: tb/tb_tune_scheduler.sv
// Scoreboard bench for tune_scheduler. Stimulus pushes the expected sequence
// of output changes (speaker, play, busy, done) and how many cycles the
// previous output value must have been held; a negedge monitor pops and
// compares whenever the observed output tuple changes.
module tb_tune_scheduler;
  localparam int TICK_DIV = 4;
  localparam int GAP_MS   = 2;
  localparam int ADDR_W   = 2;

  typedef struct {
    logic [15:0] sp;
    logic        pl;
    logic        bz;
    logic        dn;
    int          dwell;   // 0 = do not check hold time
  } ev_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  tune_if #(.ADDR_W(ADDR_W)) bus();

  tune_scheduler #(.TICK_DIV(TICK_DIV), .GAP_MS(GAP_MS), .ADDR_W(ADDR_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [24:0] table_mem [4];
  always @(posedge sys_clk) bus.mem_data <= table_mem[bus.mem_addr];

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [24:0] ent(bit e, int dur, int half);
    return {e, 8'(dur), 16'(half)};
  endfunction

  task automatic push(int sp, bit pl, bit bz, bit dn, int dwell);
    ev_t e;
    e.sp = 16'(sp); e.pl = pl; e.bz = bz; e.dn = dn; e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each change of the output tuple with the next expected event.
  logic [18:0] prev_t, cur_t;
  int          hold = 0;
  bit          mon_started = 1'b0;
  always @(negedge sys_clk) begin
    ev_t e;
    cur_t = {bus.speaker_data, bus.play, bus.busy, bus.done};
    if (!mon_started) begin
      mon_started = 1'b1;
      prev_t = cur_t;
      hold = 1;
    end else if (cur_t != prev_t) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got sp=%0d play=%0b busy=%0b done=%0b, expected no change",
                 cur_t[18:3], cur_t[2], cur_t[1], cur_t[0]);
      end else begin
        e = exp_q.pop_front();
        check("event_outputs", 32'(cur_t), 32'({e.sp, e.pl, e.bz, e.dn}));
        if (e.dwell != 0) check("event_dwell", hold, e.dwell);
      end
      prev_t = cur_t;
      hold = 1;
    end else begin
      hold++;
    end
  end

  // Wait (bounded) for every expected event, then idle to catch stray ones.
  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(posedge sys_clk);
    #1;
  endtask

  // Start pulse sampled on edge E0; returns 1 time unit after E0.
  task automatic pulse_start();
    @(posedge sys_clk); #1 bus.start = 1'b1;
    @(posedge sys_clk); #1 bus.start = 1'b0;
  endtask

  task automatic load_basic();
    table_mem[0] = ent(0, 3, 500);
    table_mem[1] = ent(1, 0, 0);
    table_mem[2] = ent(1, 0, 0);
    table_mem[3] = ent(1, 0, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.key_hold = 1'b0; bus.key_data = '0;
    load_basic();
    #2 sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_play",    32'(bus.play), 32'd0);
    check("reset_speaker", 32'(bus.speaker_data), 32'd0);
    check("reset_busy",    32'(bus.busy), 32'd0);
    check("reset_done",    32'(bus.done), 32'd0);
    check("reset_addr",    32'(bus.mem_addr), 32'd0);
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);

    // 1: single note 500 for 3 ms, 2 ms gap, end entry.
    push(0, 0, 1, 0, 0);
    push(500, 1, 1, 0, 2);
    push(0, 0, 1, 0, 12);
    push(0, 0, 0, 1, 10);
    push(0, 0, 0, 0, 1);
    pulse_start();
    drain("basic_note");

    // 2: rest entry, zero-duration skip, then a 1 ms note.
    table_mem[0] = ent(0, 2, 0);
    table_mem[1] = ent(0, 0, 123);
    table_mem[2] = ent(0, 1, 700);
    table_mem[3] = ent(1, 0, 0);
    push(0, 0, 1, 0, 0);
    push(700, 1, 1, 0, 22);
    push(0, 0, 1, 0, 4);
    push(0, 0, 0, 1, 10);
    push(0, 0, 0, 0, 1);
    pulse_start();
    drain("rest_skip");

    // 3: key 300 held 20 cycles mid-note with dur_cnt=2; note end slips by 20.
    load_basic();
    push(0, 0, 1, 0, 0);
    push(500, 1, 1, 0, 2);
    push(300, 1, 1, 0, 5);
    push(500, 1, 1, 0, 20);
    push(0, 0, 1, 0, 7);
    push(0, 0, 0, 1, 10);
    push(0, 0, 0, 0, 1);
    pulse_start();
    repeat (6) @(posedge sys_clk);
    #1 bus.key_hold = 1'b1; bus.key_data = 16'd300;
    repeat (20) @(posedge sys_clk);
    #1 bus.key_hold = 1'b0;
    drain("key_override");

    // 4a: stop in the middle of the gap; no done pulse.
    push(0, 0, 1, 0, 0);
    push(500, 1, 1, 0, 2);
    push(0, 0, 1, 0, 12);
    push(0, 0, 0, 0, 3);
    pulse_start();
    repeat (16) @(posedge sys_clk);
    #1 bus.stop = 1'b1;
    @(posedge sys_clk);
    #1 bus.stop = 1'b0;
    drain("stop_gap");

    // 4b: simultaneous start and stop in IDLE stays IDLE.
    @(posedge sys_clk);
    #1 bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge sys_clk);
    #1 bus.start = 1'b0; bus.stop = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 check("start_stop_busy", 32'(bus.busy), 32'd0);
    drain("start_stop");

    // 4c: stop while key held: melody aborts, key tone continues, then silence.
    push(0, 0, 1, 0, 0);
    push(500, 1, 1, 0, 2);
    push(300, 1, 1, 0, 3);
    push(300, 1, 0, 0, 3);
    push(0, 0, 0, 0, 3);
    pulse_start();
    repeat (4) @(posedge sys_clk);
    #1 bus.key_hold = 1'b1; bus.key_data = 16'd300;
    repeat (3) @(posedge sys_clk);
    #1 bus.stop = 1'b1;
    @(posedge sys_clk);
    #1 bus.stop = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 bus.key_hold = 1'b0;
    drain("stop_under_key");

    // 4d: key in IDLE drives the speaker without making the block busy.
    push(16'h55, 1, 0, 0, 0);
    push(0, 0, 0, 0, 3);
    @(posedge sys_clk);
    #1 bus.key_hold = 1'b1; bus.key_data = 16'h0055;
    repeat (3) @(posedge sys_clk);
    #1 bus.key_hold = 1'b0;
    drain("key_idle");

    // 5: full table of four 1 ms notes; done after addr 3, address does not wrap.
    table_mem[0] = ent(0, 1, 100);
    table_mem[1] = ent(0, 1, 200);
    table_mem[2] = ent(0, 1, 300);
    table_mem[3] = ent(0, 1, 400);
    push(0, 0, 1, 0, 0);
    push(100, 1, 1, 0, 2);
    push(0, 0, 1, 0, 4);
    push(200, 1, 1, 0, 10);
    push(0, 0, 1, 0, 4);
    push(300, 1, 1, 0, 10);
    push(0, 0, 1, 0, 4);
    push(400, 1, 1, 0, 10);
    push(0, 0, 1, 0, 4);
    push(0, 0, 0, 1, 8);
    push(0, 0, 0, 0, 1);
    pulse_start();
    drain("full_table");
    check("full_table_addr", 32'(bus.mem_addr), 32'd3);

    // 6: async reset mid-note, then a fresh start replays from address 0.
    table_mem[0] = ent(0, 1, 100);
    table_mem[1] = ent(1, 0, 0);
    push(0, 0, 1, 0, 0);
    push(100, 1, 1, 0, 2);
    push(0, 0, 0, 0, 2);
    pulse_start();
    repeat (4) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    check("async_rst_play",    32'(bus.play), 32'd0);
    check("async_rst_speaker", 32'(bus.speaker_data), 32'd0);
    check("async_rst_busy",    32'(bus.busy), 32'd0);
    check("async_rst_addr",    32'(bus.mem_addr), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    drain("reset_mid_note");
    push(0, 0, 1, 0, 0);
    push(100, 1, 1, 0, 2);
    push(0, 0, 1, 0, 4);
    push(0, 0, 0, 1, 10);
    push(0, 0, 0, 0, 1);
    pulse_start();
    drain("replay_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "time limit");
  end
endmodule
